// File: rtl/matrix_generate_2x2_8bit.sv
// 2x2 neighbourhood generator for a raster gray stream, with one line buffered in a single-port RAM.
// Optional build macro MATRIX_ZERO_PAD_EN: zero-pad missing top/left pixels instead of replicating.
module matrix_generate_2x2_8bit #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_img_vsync,
  input  logic       per_img_href,
  input  logic [7:0] per_img_gray,
  output logic       matrix_img_vsync,
  output logic       matrix_img_href,
  output logic       matrix_top_edge_flag,
  output logic       matrix_left_edge_flag,
  output logic [7:0] matrix_p11,
  output logic [7:0] matrix_p12,
  output logic [7:0] matrix_p21,
  output logic [7:0] matrix_p22
);

  localparam int unsigned CW    = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = int'(IMG_HDISP);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] H_LAST = IMG_HDISP - CW'(1);
  localparam logic [CW-1:0] V_LAST = IMG_VDISP - CW'(1);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          href_d;
  logic          hsat;

  logic [DW-1:0] line_ram [DEPTH];
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] up1;

  logic          href1;
  logic          vsync1;
  logic          top1;
  logic          left1;
  logic [DW-1:0] cur1;

  logic [DW-1:0] p11_next;
  logic [DW-1:0] p12_next;
  logic [DW-1:0] p21_next;

  // Column counter; hsat marks that the last in-range column has been written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      hsat   <= 1'b0;
      href_d <= 1'b0;
    end else begin
      href_d <= per_img_href;
      if (per_img_href) begin
        if (hcnt != H_LAST) hcnt <= hcnt + CW'(1);
        else                hsat <= 1'b1;
      end else begin
        hcnt <= '0;
        hsat <= 1'b0;
      end
    end
  end

  // Line counter advances on each href falling edge within a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt <= '0;
    end else if (!per_img_vsync) begin
      vcnt <= '0;
    end else if (href_d && !per_img_href && (vcnt != V_LAST)) begin
      vcnt <= vcnt + CW'(1);
    end
  end

  assign ram_addr = hcnt[AW-1:0];

  // Read-before-write line buffer; overflow pixels past the line width are not stored.
  always_ff @(posedge clk) begin
    if (per_img_href) begin
      up1 <= line_ram[ram_addr];
      if (!hsat) line_ram[ram_addr] <= per_img_gray;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur1   <= '0;
      href1  <= 1'b0;
      vsync1 <= 1'b0;
      top1   <= 1'b0;
      left1  <= 1'b0;
    end else begin
      cur1   <= per_img_gray;
      href1  <= per_img_href;
      vsync1 <= per_img_vsync;
      top1   <= (vcnt == '0);
      left1  <= (hcnt == '0);
    end
  end

  // Window column selection with boundary handling.
  always_comb begin
    p12_next = top1 ? cur1 : up1;
    p21_next = left1 ? cur1 : matrix_p22;
    p11_next = left1 ? p12_next : (top1 ? matrix_p22 : matrix_p12);
`ifdef MATRIX_ZERO_PAD_EN
    if (top1) begin
      p12_next = '0;
      p11_next = '0;
    end
    if (left1) begin
      p21_next = '0;
      p11_next = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_img_vsync      <= 1'b0;
      matrix_img_href       <= 1'b0;
      matrix_top_edge_flag  <= 1'b0;
      matrix_left_edge_flag <= 1'b0;
      matrix_p11            <= '0;
      matrix_p12            <= '0;
      matrix_p21            <= '0;
      matrix_p22            <= '0;
    end else begin
      matrix_img_vsync <= vsync1;
      matrix_img_href  <= href1;
      if (href1) begin
        matrix_top_edge_flag  <= top1;
        matrix_left_edge_flag <= left1;
        matrix_p11            <= p11_next;
        matrix_p12            <= p12_next;
        matrix_p21            <= p21_next;
        matrix_p22            <= cur1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_generate_2x2_8bit.sv
// Bench for matrix_generate_2x2_8bit: column-pair window model, per-cycle compare, literal pins.
module tb_matrix_generate_2x2_8bit;

  localparam int H = 4;
  localparam int V = 3;
`ifdef MATRIX_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic       top;
    logic       left;
    logic [7:0] p11;
    logic [7:0] p12;
    logic [7:0] p21;
    logic [7:0] p22;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] gray = 8'd0;

  logic       o_vs, o_hr, o_top, o_left;
  logic [7:0] o_p11, o_p12, o_p21, o_p22;

  matrix_generate_2x2_8bit #(.IMG_HDISP(11'd4), .IMG_VDISP(11'd3)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_img_vsync(vsync), .per_img_href(href), .per_img_gray(gray),
    .matrix_img_vsync(o_vs), .matrix_img_href(o_hr),
    .matrix_top_edge_flag(o_top), .matrix_left_edge_flag(o_left),
    .matrix_p11(o_p11), .matrix_p12(o_p12), .matrix_p21(o_p21), .matrix_p22(o_p22)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  out_t dut_o;
  assign dut_o = '{vs: o_vs, hr: o_hr, top: o_top, left: o_left,
                   p11: o_p11, p12: o_p12, p21: o_p21, p22: o_p22};

  // Model: each pixel forms a column (above, current); the window is the previous column and this one.
  out_t       exp_now = '0;
  out_t       exp_pend = '0;
  logic [7:0] mem [H];
  int         m_k = 0;
  int         m_y = 0;
  bit         m_prev_href = 1'b0;
  logic [7:0] prev_top = '0;
  logic [7:0] prev_bot = '0;

  always @(posedge clk or negedge rst_n) begin
    out_t       nxt;
    int         x;
    logic [7:0] ct, cb, lt, lb;
    if (!rst_n) begin
      exp_now = '0;
      exp_pend = '0;
      m_k = 0;
      m_y = 0;
      m_prev_href = 1'b0;
      prev_top = '0;
      prev_bot = '0;
    end else begin
      exp_now = exp_pend;
      nxt = exp_pend;
      nxt.vs = vsync;
      nxt.hr = href;
      if (href) begin
        x  = (m_k >= H) ? H - 1 : m_k;
        cb = gray;
        ct = (m_y == 0) ? (ZP ? 8'd0 : gray) : mem[x];
        if (m_k == 0) begin
          lt = ZP ? 8'd0 : ct;
          lb = ZP ? 8'd0 : cb;
        end else begin
          lt = prev_top;
          lb = prev_bot;
        end
        nxt.top  = (m_y == 0);
        nxt.left = (m_k == 0);
        nxt.p11 = lt; nxt.p21 = lb; nxt.p12 = ct; nxt.p22 = cb;
        if (m_k < H) mem[x] = gray;
        prev_top = ct;
        prev_bot = cb;
        m_k++;
      end else begin
        m_k = 0;
      end
      if (!vsync) m_y = 0;
      else if (m_prev_href && !href && m_y < V - 1) m_y++;
      m_prev_href = href;
      exp_pend = nxt;
    end
  end

  bit   capture = 1'b0;
  out_t obs[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", dut_o, 36'd0);
    end else begin
      chk("cycle_model", dut_o, exp_now);
      if (capture && o_hr) obs.push_back(dut_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input bit h, input logic [7:0] g);
    vsync = v; href = h; gray = g;
    tick();
  endtask

  // fixed_w > 0: fixed width and 2-cycle line gaps; seq: pixel value base + row*4 + col.
  task automatic run_frame(input int rows, input int fixed_w, input bit seq, input int base, input int vgap);
    int w;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    for (int r = 0; r < rows; r++) begin
      w = (fixed_w > 0) ? fixed_w : int'($urandom_range(1, 5));
      for (int c = 0; c < w; c++)
        drive(1'b1, 1'b1, seq ? 8'(base + r * 4 + c) : 8'($urandom_range(0, 255)));
      repeat ((fixed_w > 0) ? 2 : int'($urandom_range(1, 3))) drive(1'b1, 1'b0, 8'd0);
    end
    repeat (vgap) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic lit(input string name, input int idx, input bit t, input bit l,
                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    out_t e;
    e = '{vs: 1'b1, hr: 1'b1, top: t, left: l, p11: a, p12: b, p21: c, p22: d};
    if (idx < obs.size()) chk(name, obs[idx], e);
    else chk({name, "_missing"}, 36'(obs.size()), 36'(idx + 1));
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed 4x3 frame of values 0..11.
    obs.delete();
    capture = 1'b1;
    run_frame(3, 4, 1'b1, 0, 4);
    capture = 1'b0;
    chk("directed_count", 36'(obs.size()), 36'd12);
    lit("pix0", 0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    lit("pix5", 5, 1'b0, 1'b0, 8'd0, 8'd1, 8'd4, 8'd5);
    if (ZP) begin
      lit("pix2_zp", 2, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 8'd2);
      lit("pix8_zp", 8, 1'b0, 1'b1, 8'd0, 8'd4, 8'd0, 8'd8);
    end else begin
      lit("pix2", 2, 1'b1, 1'b0, 8'd1, 8'd2, 8'd1, 8'd2);
      lit("pix8", 8, 1'b0, 1'b1, 8'd4, 8'd4, 8'd8, 8'd8);
    end

    // Five-cycle href gap inside a frame.
    drive(1'b1, 1'b0, 8'd0);
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, 8'(20 + c));
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd30);
    drive(1'b1, 1'b1, 8'd31);
    repeat (5) drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd40);
    drive(1'b1, 1'b1, 8'd41);
    repeat (3) drive(1'b0, 1'b0, 8'd0);

    // Reset asserted mid-line 1, then a fresh frame.
    drive(1'b1, 1'b0, 8'd0);
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, 8'(50 + c));
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd60);
    drive(1'b1, 1'b1, 8'd61);
    vsync = 1'b1; href = 1'b1; gray = 8'd62;
    rst_n = 1'b0;
    #1;
    chk("async_reset", dut_o, 36'd0);
    tick();
    vsync = 1'b0; href = 1'b0; gray = 8'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    obs.delete();
    capture = 1'b1;
    run_frame(2, 4, 1'b1, 100, 4);
    capture = 1'b0;
    if (ZP) lit("post_reset_pix0", 0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd100);
    else    lit("post_reset_pix0", 0, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 8'd100);

    // Back-to-back frames separated by four vsync-low cycles.
    run_frame(3, 4, 1'b0, 0, 4);
    obs.delete();
    capture = 1'b1;
    run_frame(2, 4, 1'b1, 200, 4);
    capture = 1'b0;
    if (ZP) lit("frame2_pix1", 1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd200, 8'd201);
    else    lit("frame2_pix1", 1, 1'b1, 1'b0, 8'd200, 8'd201, 8'd200, 8'd201);

    // Random frames: variable heights, widths (with overflow), gaps.
    for (int f = 0; f < 30; f++)
      run_frame(int'($urandom_range(1, 5)), 0, 1'b0, 0, int'($urandom_range(1, 4)));

    repeat (4) drive(1'b0, 1'b0, 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
